// File: rtl/integer_execute_if.sv
// Issue-side bundle into the integer execute stage plus its registered result,
// resolve and redirect outputs.
interface integer_execute_if #(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned ROB_ID_WIDTH = 5
) ();

   logic                    issue_valid;
   logic [XLEN-1:0]         src1_data;
   logic [XLEN-1:0]         src2_data;
   logic [XLEN-1:0]         imm;
   logic [XLEN-1:0]         pc;
   logic [ROB_ID_WIDTH-1:0] rob_id;
   logic [2:0]              funct3;
   logic                    is_r_type;
   logic                    is_i_type;
   logic                    is_b_type;
   logic                    is_u_type;
   logic                    is_j_type;
   logic                    is_sub;
   logic                    is_sra_srai;
   logic                    is_lui;
   logic                    is_jalr;
   logic                    br_dir_pred;

   logic [ROB_ID_WIDTH-1:0] rob_head_id;
   logic                    recovery_done;

   logic                    alu_broadcast_valid;
   logic [ROB_ID_WIDTH-1:0] alu_broadcast_rob_id;
   logic [XLEN-1:0]         alu_broadcast_reg_data;
   logic                    br_resolve_valid;
   logic [ROB_ID_WIDTH-1:0] br_resolve_rob_id;
   logic                    br_resolve_taken;
   logic                    redirect_valid;
   logic [XLEN-1:0]         redirect_pc;
   logic                    recovering;

   modport master (
      output issue_valid, src1_data, src2_data, imm, pc, rob_id, funct3,
             is_r_type, is_i_type, is_b_type, is_u_type, is_j_type,
             is_sub, is_sra_srai, is_lui, is_jalr, br_dir_pred,
             rob_head_id, recovery_done,
      input  alu_broadcast_valid, alu_broadcast_rob_id, alu_broadcast_reg_data,
             br_resolve_valid, br_resolve_rob_id, br_resolve_taken,
             redirect_valid, redirect_pc, recovering
   );

   modport slave (
      input  issue_valid, src1_data, src2_data, imm, pc, rob_id, funct3,
             is_r_type, is_i_type, is_b_type, is_u_type, is_j_type,
             is_sub, is_sra_srai, is_lui, is_jalr, br_dir_pred,
             rob_head_id, recovery_done,
      output alu_broadcast_valid, alu_broadcast_rob_id, alu_broadcast_reg_data,
             br_resolve_valid, br_resolve_rob_id, br_resolve_taken,
             redirect_valid, redirect_pc, recovering
   );

endinterface

// File: rtl/integer_execute.sv
// Integer execute stage: single-cycle ALU/branch evaluation with registered outputs
// and wrong-path squashing while the ROB recovers from a mispredict.
module integer_execute #(
   parameter int unsigned XLEN         = 32,
   parameter int unsigned ROB_ID_WIDTH = 5
) (
   input logic               clk,
   input logic               rst_aL,
   integer_execute_if.slave  bus
);

   localparam logic [0:0] StIdle    = 1'b0;
   localparam logic [0:0] StRecover = 1'b1;

   logic [0:0]              state_q, state_d;
   logic [ROB_ID_WIDTH-1:0] saved_tag_q, saved_tag_d;

   logic [XLEN-1:0] op2;
   logic [4:0]      shamt;
   logic [XLEN-1:0] add_res;
   logic [XLEN-1:0] sub_res;
   logic [XLEN-1:0] alu_res;
   logic [XLEN-1:0] pc_plus_imm;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] jalr_sum;
   logic [XLEN-1:0] jalr_target;
   logic [XLEN-1:0] result;
   logic            lt_s;
   logic            lt_u;
   logic            eq;
   logic            br_cond;

   logic            is_jump;
   logic            is_ctrl;
   logic            taken;
   logic [XLEN-1:0] target;
   logic            mispredict;
   logic [XLEN-1:0] next_pc;

   logic [ROB_ID_WIDTH-1:0] age_in;
   logic [ROB_ID_WIDTH-1:0] age_saved;
   logic                    older;
   logic                    squash;
   logic                    exec;

   assign op2   = bus.is_r_type ? bus.src2_data : bus.imm;
   assign shamt = op2[4:0];

   assign add_res = bus.src1_data + op2;
   assign sub_res = bus.src1_data - op2;
   assign lt_s    = $signed(bus.src1_data) < $signed(op2);
   assign lt_u    = bus.src1_data < op2;

   always_comb begin
      alu_res = '0;
      unique case (bus.funct3)
         3'b000: alu_res = (bus.is_r_type && bus.is_sub) ? sub_res : add_res;
         3'b001: alu_res = bus.src1_data << shamt;
         3'b010: alu_res = {{(XLEN-1){1'b0}}, lt_s};
         3'b011: alu_res = {{(XLEN-1){1'b0}}, lt_u};
         3'b100: alu_res = bus.src1_data ^ op2;
         3'b101: alu_res = bus.is_sra_srai ? XLEN'($signed(bus.src1_data) >>> shamt)
                                           : bus.src1_data >> shamt;
         3'b110: alu_res = bus.src1_data | op2;
         3'b111: alu_res = bus.src1_data & op2;
         default: alu_res = '0;
      endcase
   end

   assign pc_plus_imm = bus.pc + bus.imm;
   assign pc_plus4    = bus.pc + XLEN'(4);
   assign jalr_sum    = bus.src1_data + bus.imm;
   assign jalr_target = {jalr_sum[XLEN-1:1], 1'b0};

   // Branches always compare the two register sources, never the immediate.
   assign eq = bus.src1_data == bus.src2_data;

   always_comb begin
      br_cond = 1'b0;
      case (bus.funct3)
         3'b000: br_cond = eq;
         3'b001: br_cond = !eq;
         3'b100: br_cond = $signed(bus.src1_data) < $signed(bus.src2_data);
         3'b101: br_cond = $signed(bus.src1_data) >= $signed(bus.src2_data);
         3'b110: br_cond = bus.src1_data < bus.src2_data;
         3'b111: br_cond = bus.src1_data >= bus.src2_data;
         default: br_cond = 1'b0;
      endcase
   end

   always_comb begin
      result = '0;
      if (bus.is_u_type) begin
         result = bus.is_lui ? bus.imm : pc_plus_imm;
      end else if (bus.is_j_type || bus.is_jalr) begin
         result = pc_plus4;
      end else if (bus.is_r_type || bus.is_i_type) begin
         result = alu_res;
      end
   end

   assign is_jump    = bus.is_j_type || bus.is_jalr;
   assign is_ctrl    = bus.is_b_type || is_jump;
   assign taken      = is_jump || (bus.is_b_type && br_cond);
   assign target     = bus.is_jalr ? jalr_target : pc_plus_imm;
   assign mispredict = bus.is_b_type ? (br_cond != bus.br_dir_pred) : bus.is_jalr;
   assign next_pc    = taken ? target : pc_plus4;

   // Ages are distances from the ROB head, so tag wrap-around falls out of the subtraction.
   assign age_in    = bus.rob_id - bus.rob_head_id;
   assign age_saved = saved_tag_q - bus.rob_head_id;
   assign older     = age_in < age_saved;
   assign squash    = (state_q == StRecover) && !older;
   assign exec      = bus.issue_valid && !squash;

   // A fresh mispredict outranks a same-cycle recovery_done: a new recovery is starting.
   always_comb begin
      state_d     = state_q;
      saved_tag_d = saved_tag_q;
      if (exec && is_ctrl && mispredict) begin
         state_d     = StRecover;
         saved_tag_d = bus.rob_id;
      end else if ((state_q == StRecover) && bus.recovery_done) begin
         state_d = StIdle;
      end
   end

   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         state_q     <= StIdle;
         saved_tag_q <= '0;
      end else begin
         state_q     <= state_d;
         saved_tag_q <= saved_tag_d;
      end
   end

   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         bus.alu_broadcast_valid    <= 1'b0;
         bus.alu_broadcast_rob_id   <= '0;
         bus.alu_broadcast_reg_data <= '0;
         bus.br_resolve_valid       <= 1'b0;
         bus.br_resolve_rob_id      <= '0;
         bus.br_resolve_taken       <= 1'b0;
         bus.redirect_valid         <= 1'b0;
         bus.redirect_pc            <= '0;
      end else begin
         bus.alu_broadcast_valid    <= exec && !bus.is_b_type;
         bus.alu_broadcast_rob_id   <= exec ? bus.rob_id : '0;
         bus.alu_broadcast_reg_data <= (exec && !bus.is_b_type) ? result : '0;
         bus.br_resolve_valid       <= exec && is_ctrl;
         bus.br_resolve_rob_id      <= (exec && is_ctrl) ? bus.rob_id : '0;
         bus.br_resolve_taken       <= exec && is_ctrl && taken;
         bus.redirect_valid         <= exec && is_ctrl && mispredict;
         bus.redirect_pc            <= (exec && is_ctrl && mispredict) ? next_pc : '0;
      end
   end

   assign bus.recovering = (state_q == StRecover);

endmodule

// File: tb/tb_integer_execute.sv
// Directed-vector bench for integer_execute: ALU ops, branches, jumps, recovery
// squashing with wrapping ROB tags, and asynchronous reset.
module tb_integer_execute;

   logic clk;
   logic rst_aL;
   int   total;
   int   bad;

   integer_execute_if #(.XLEN(32), .ROB_ID_WIDTH(5)) bus ();

   integer_execute #(.XLEN(32), .ROB_ID_WIDTH(5)) dut (
      .clk    (clk),
      .rst_aL (rst_aL),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_op();
      bus.issue_valid = 1'b0;
      bus.src1_data   = '0;
      bus.src2_data   = '0;
      bus.imm         = '0;
      bus.pc          = '0;
      bus.rob_id      = '0;
      bus.funct3      = '0;
      bus.is_r_type   = 1'b0;
      bus.is_i_type   = 1'b0;
      bus.is_b_type   = 1'b0;
      bus.is_u_type   = 1'b0;
      bus.is_j_type   = 1'b0;
      bus.is_sub      = 1'b0;
      bus.is_sra_srai = 1'b0;
      bus.is_lui      = 1'b0;
      bus.is_jalr     = 1'b0;
      bus.br_dir_pred = 1'b0;
   endtask

   // Drive an op (already set up) through one rising edge, then sample #1 after it.
   task automatic step();
      @(posedge clk);
      #1;
      clear_op();
   endtask

   task automatic add_op(input logic [4:0] id, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      clear_op();
      bus.issue_valid = 1'b1;
      bus.is_r_type   = 1'b1;
      bus.funct3      = 3'b000;
      bus.rob_id      = id;
      bus.src1_data   = a;
      bus.src2_data   = b;
      step();
   endtask

   task automatic test_reset();
      total++;
      if ({bus.alu_broadcast_valid, bus.br_resolve_valid, bus.redirect_valid,
           bus.recovering} !== 4'b0 || bus.alu_broadcast_reg_data !== 32'h0 ||
          bus.redirect_pc !== 32'h0) begin
         $display("FAIL reset_outputs got bv=%b rv=%b dv=%b rec=%b data=%h pc=%h exp all 0",
                  bus.alu_broadcast_valid, bus.br_resolve_valid, bus.redirect_valid,
                  bus.recovering, bus.alu_broadcast_reg_data, bus.redirect_pc);
         bad++;
      end
   endtask

   task automatic test_alu();
      add_op(5'd3, 32'd7, 32'd5);
      total++;
      if (bus.alu_broadcast_valid !== 1'b1 || bus.alu_broadcast_rob_id !== 5'd3 ||
          bus.alu_broadcast_reg_data !== 32'd12) begin
         $display("FAIL add got v=%b id=%0d d=%h exp v=1 id=3 d=0000000c",
                  bus.alu_broadcast_valid, bus.alu_broadcast_rob_id, bus.alu_broadcast_reg_data);
         bad++;
      end

      @(negedge clk);
      bus.issue_valid = 1'b1; bus.is_i_type = 1'b1; bus.funct3 = 3'b101;
      bus.is_sra_srai = 1'b1; bus.src1_data = 32'h8000_0000; bus.imm = 32'd4;
      step();
      total++;
      if (bus.alu_broadcast_reg_data !== 32'hF800_0000) begin
         $display("FAIL srai got %h exp f8000000", bus.alu_broadcast_reg_data);
         bad++;
      end

      @(negedge clk);
      bus.issue_valid = 1'b1; bus.is_r_type = 1'b1; bus.is_sub = 1'b1;
      bus.src1_data = 32'd5; bus.src2_data = 32'd7;
      step();
      total++;
      if (bus.alu_broadcast_reg_data !== 32'hFFFF_FFFE) begin
         $display("FAIL sub got %h exp fffffffe", bus.alu_broadcast_reg_data);
         bad++;
      end

      @(negedge clk);
      bus.issue_valid = 1'b1; bus.is_r_type = 1'b1; bus.funct3 = 3'b010;
      bus.src1_data = 32'hFFFF_FFFF; bus.src2_data = 32'd1;
      step();
      total++;
      if (bus.alu_broadcast_reg_data !== 32'd1) begin
         $display("FAIL slt got %h exp 00000001", bus.alu_broadcast_reg_data);
         bad++;
      end

      @(negedge clk);
      bus.issue_valid = 1'b1; bus.is_r_type = 1'b1; bus.funct3 = 3'b011;
      bus.src1_data = 32'hFFFF_FFFF; bus.src2_data = 32'd1;
      step();
      total++;
      if (bus.alu_broadcast_reg_data !== 32'd0) begin
         $display("FAIL sltu got %h exp 00000000", bus.alu_broadcast_reg_data);
         bad++;
      end

      // Only imm[4:0] counts as shift amount.
      @(negedge clk);
      bus.issue_valid = 1'b1; bus.is_i_type = 1'b1; bus.funct3 = 3'b001;
      bus.src1_data = 32'd1; bus.imm = 32'h24;
      step();
      total++;
      if (bus.alu_broadcast_reg_data !== 32'h10) begin
         $display("FAIL slli got %h exp 00000010", bus.alu_broadcast_reg_data);
         bad++;
      end

      // is_sub on an I-type must not turn addi into a subtract; sum wraps.
      @(negedge clk);
      bus.issue_valid = 1'b1; bus.is_i_type = 1'b1; bus.is_sub = 1'b1;
      bus.src1_data = 32'hFFFF_FFFF; bus.imm = 32'd1;
      step();
      total++;
      if (bus.alu_broadcast_reg_data !== 32'h0 || bus.alu_broadcast_valid !== 1'b1) begin
         $display("FAIL addi_wrap got v=%b d=%h exp v=1 d=00000000",
                  bus.alu_broadcast_valid, bus.alu_broadcast_reg_data);
         bad++;
      end

      @(negedge clk);
      bus.issue_valid = 1'b1; bus.is_u_type = 1'b1; bus.is_lui = 1'b1;
      bus.pc = 32'h1000; bus.imm = 32'h1234_5000;
      step();
      total++;
      if (bus.alu_broadcast_reg_data !== 32'h1234_5000) begin
         $display("FAIL lui got %h exp 12345000", bus.alu_broadcast_reg_data);
         bad++;
      end

      @(negedge clk);
      bus.issue_valid = 1'b1; bus.is_u_type = 1'b1;
      bus.pc = 32'h1000; bus.imm = 32'h2000;
      step();
      total++;
      if (bus.alu_broadcast_reg_data !== 32'h3000) begin
         $display("FAIL auipc got %h exp 00003000", bus.alu_broadcast_reg_data);
         bad++;
      end

      @(negedge clk);
      bus.issue_valid = 1'b1; bus.is_j_type = 1'b1; bus.rob_id = 5'd7;
      bus.pc = 32'h200; bus.imm = 32'h40;
      step();
      total++;
      if (bus.alu_broadcast_reg_data !== 32'h204 || bus.br_resolve_valid !== 1'b1 ||
          bus.br_resolve_taken !== 1'b1 || bus.br_resolve_rob_id !== 5'd7 ||
          bus.redirect_valid !== 1'b0 || bus.recovering !== 1'b0) begin
         $display("FAIL jal got d=%h rv=%b tk=%b id=%0d dv=%b rec=%b exp d=204 1 1 7 0 0",
                  bus.alu_broadcast_reg_data, bus.br_resolve_valid, bus.br_resolve_taken,
                  bus.br_resolve_rob_id, bus.redirect_valid, bus.recovering);
         bad++;
      end

      // Correctly predicted not-taken bge: resolve only, no broadcast, no redirect.
      @(negedge clk);
      bus.issue_valid = 1'b1; bus.is_b_type = 1'b1; bus.funct3 = 3'b101;
      bus.src1_data = 32'hFFFF_FFFF; bus.src2_data = 32'd1; bus.imm = 32'h80;
      bus.recovery_done = 1'b1;
      step();
      bus.recovery_done = 1'b0;
      total++;
      if (bus.br_resolve_valid !== 1'b1 || bus.br_resolve_taken !== 1'b0 ||
          bus.alu_broadcast_valid !== 1'b0 || bus.redirect_valid !== 1'b0 ||
          bus.recovering !== 1'b0) begin
         $display("FAIL bge_nt got rv=%b tk=%b bv=%b dv=%b rec=%b exp 1 0 0 0 0",
                  bus.br_resolve_valid, bus.br_resolve_taken, bus.alu_broadcast_valid,
                  bus.redirect_valid, bus.recovering);
         bad++;
      end
   endtask

   task automatic test_branch_mispredict();
      @(negedge clk);
      bus.rob_head_id = 5'd4;
      bus.issue_valid = 1'b1; bus.is_b_type = 1'b1; bus.funct3 = 3'b000;
      bus.src1_data = 32'd9; bus.src2_data = 32'd9; bus.pc = 32'h100; bus.imm = 32'h20;
      bus.rob_id = 5'd6; bus.br_dir_pred = 1'b0;
      step();
      total++;
      if (bus.br_resolve_valid !== 1'b1 || bus.br_resolve_taken !== 1'b1 ||
          bus.br_resolve_rob_id !== 5'd6 || bus.redirect_valid !== 1'b1 ||
          bus.redirect_pc !== 32'h120 || bus.recovering !== 1'b1 ||
          bus.alu_broadcast_valid !== 1'b0) begin
         $display("FAIL beq_mispredict got rv=%b tk=%b id=%0d dv=%b pc=%h rec=%b bv=%b exp 1 1 6 1 120 1 0",
                  bus.br_resolve_valid, bus.br_resolve_taken, bus.br_resolve_rob_id,
                  bus.redirect_valid, bus.redirect_pc, bus.recovering, bus.alu_broadcast_valid);
         bad++;
      end
      @(negedge clk);
      step();
      total++;
      if (bus.redirect_valid !== 1'b0 || bus.recovering !== 1'b1) begin
         $display("FAIL redirect_pulse got dv=%b rec=%b exp dv=0 rec=1",
                  bus.redirect_valid, bus.recovering);
         bad++;
      end
   endtask

   task automatic test_recover_squash();
      add_op(5'd8, 32'd1, 32'd1);
      total++;
      if (bus.alu_broadcast_valid !== 1'b0 || bus.br_resolve_valid !== 1'b0) begin
         $display("FAIL squash_young got bv=%b rv=%b exp 0 0",
                  bus.alu_broadcast_valid, bus.br_resolve_valid);
         bad++;
      end
      add_op(5'd5, 32'd1, 32'd2);
      total++;
      if (bus.alu_broadcast_valid !== 1'b1 || bus.alu_broadcast_rob_id !== 5'd5 ||
          bus.alu_broadcast_reg_data !== 32'd3) begin
         $display("FAIL older_exec got v=%b id=%0d d=%h exp 1 5 00000003",
                  bus.alu_broadcast_valid, bus.alu_broadcast_rob_id, bus.alu_broadcast_reg_data);
         bad++;
      end
   endtask

   task automatic test_nested_mispredict();
      @(negedge clk);
      bus.issue_valid = 1'b1; bus.is_b_type = 1'b1; bus.funct3 = 3'b001;
      bus.src1_data = 32'd1; bus.src2_data = 32'd2; bus.pc = 32'h300; bus.imm = 32'h10;
      bus.rob_id = 5'd5; bus.br_dir_pred = 1'b0;
      step();
      total++;
      if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h310 ||
          bus.br_resolve_rob_id !== 5'd5 || bus.recovering !== 1'b1) begin
         $display("FAIL nested_redirect got dv=%b pc=%h id=%0d rec=%b exp 1 310 5 1",
                  bus.redirect_valid, bus.redirect_pc, bus.br_resolve_rob_id, bus.recovering);
         bad++;
      end
      // Tag 6 was the old saved tag; with tag 5 saved it is now wrong-path.
      add_op(5'd6, 32'd1, 32'd1);
      total++;
      if (bus.alu_broadcast_valid !== 1'b0) begin
         $display("FAIL new_tag_squash got bv=%b exp 0", bus.alu_broadcast_valid);
         bad++;
      end
      add_op(5'd4, 32'd2, 32'd2);
      total++;
      if (bus.alu_broadcast_valid !== 1'b1 || bus.alu_broadcast_reg_data !== 32'd4) begin
         $display("FAIL new_tag_older got v=%b d=%h exp 1 00000004",
                  bus.alu_broadcast_valid, bus.alu_broadcast_reg_data);
         bad++;
      end
      @(negedge clk);
      bus.recovery_done = 1'b1;
      step();
      bus.recovery_done = 1'b0;
      total++;
      if (bus.recovering !== 1'b0) begin
         $display("FAIL recover_exit got rec=%b exp 0", bus.recovering);
         bad++;
      end
   endtask

   task automatic test_wrap();
      @(negedge clk);
      bus.rob_head_id = 5'd30;
      bus.issue_valid = 1'b1; bus.is_b_type = 1'b1; bus.funct3 = 3'b000;
      bus.pc = 32'h500; bus.imm = 32'h8; bus.rob_id = 5'd1; bus.br_dir_pred = 1'b0;
      step();
      total++;
      if (bus.recovering !== 1'b1 || bus.redirect_pc !== 32'h508) begin
         $display("FAIL wrap_enter got rec=%b pc=%h exp 1 508", bus.recovering, bus.redirect_pc);
         bad++;
      end
      add_op(5'd31, 32'd10, 32'd20);
      total++;
      if (bus.alu_broadcast_valid !== 1'b1 || bus.alu_broadcast_reg_data !== 32'd30) begin
         $display("FAIL wrap_older got v=%b d=%h exp 1 0000001e",
                  bus.alu_broadcast_valid, bus.alu_broadcast_reg_data);
         bad++;
      end
      // Same-cycle op and recovery_done: the op is still age-checked and squashed.
      @(negedge clk);
      bus.issue_valid = 1'b1; bus.is_r_type = 1'b1; bus.rob_id = 5'd2;
      bus.src1_data = 32'd1; bus.src2_data = 32'd1; bus.recovery_done = 1'b1;
      step();
      bus.recovery_done = 1'b0;
      total++;
      if (bus.alu_broadcast_valid !== 1'b0 || bus.recovering !== 1'b0) begin
         $display("FAIL wrap_squash_exit got bv=%b rec=%b exp 0 0",
                  bus.alu_broadcast_valid, bus.recovering);
         bad++;
      end
   endtask

   task automatic test_jalr_and_reset();
      @(negedge clk);
      bus.rob_head_id = 5'd8;
      bus.issue_valid = 1'b1; bus.is_jalr = 1'b1; bus.rob_id = 5'd10;
      bus.pc = 32'h400; bus.src1_data = 32'h203; bus.imm = 32'h0;
      step();
      total++;
      if (bus.alu_broadcast_valid !== 1'b1 || bus.alu_broadcast_reg_data !== 32'h404 ||
          bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h202 ||
          bus.br_resolve_taken !== 1'b1 || bus.recovering !== 1'b1) begin
         $display("FAIL jalr got bv=%b d=%h dv=%b pc=%h tk=%b rec=%b exp 1 404 1 202 1 1",
                  bus.alu_broadcast_valid, bus.alu_broadcast_reg_data, bus.redirect_valid,
                  bus.redirect_pc, bus.br_resolve_taken, bus.recovering);
         bad++;
      end
      rst_aL = 1'b0;
      #1;
      total++;
      if ({bus.alu_broadcast_valid, bus.br_resolve_valid, bus.br_resolve_taken,
           bus.redirect_valid, bus.recovering} !== 5'b0 ||
          bus.alu_broadcast_reg_data !== 32'h0 || bus.redirect_pc !== 32'h0) begin
         $display("FAIL async_reset got bv=%b rv=%b dv=%b rec=%b d=%h pc=%h exp all 0",
                  bus.alu_broadcast_valid, bus.br_resolve_valid, bus.redirect_valid,
                  bus.recovering, bus.alu_broadcast_reg_data, bus.redirect_pc);
         bad++;
      end
      @(negedge clk);
      rst_aL = 1'b1;
      add_op(5'd20, 32'd3, 32'd4);
      total++;
      if (bus.alu_broadcast_valid !== 1'b1 || bus.alu_broadcast_reg_data !== 32'd7 ||
          bus.recovering !== 1'b0) begin
         $display("FAIL post_reset got v=%b d=%h rec=%b exp 1 00000007 0",
                  bus.alu_broadcast_valid, bus.alu_broadcast_reg_data, bus.recovering);
         bad++;
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      clear_op();
      bus.rob_head_id   = '0;
      bus.recovery_done = 1'b0;
      rst_aL = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      @(negedge clk);
      rst_aL = 1'b1;
      test_alu();
      test_branch_mispredict();
      test_recover_squash();
      test_nested_mispredict();
      test_wrap();
      test_jalr_and_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
